pipelined_and_reduce: RTL and testbench
=======================================

PIPELINED_AND_REDUCE -- requirements
Module: pipelined_and_reduce

Interface
REQ-001 Parameter WIDTH, default 16, total input data bits; SHALL be a multiple of LANE_W.
REQ-002 Parameter LANE_W, default 1, bits per lane; SHALL divide WIDTH.
REQ-003 Parameter GROUP, default 4, lanes per stage-1 partial reduction; the last group SHALL be partial if lanes is not a multiple of GROUP.
REQ-004 Parameter CNT_W, default 8, width of the beat counter.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block accepts the beat this cycle.
REQ-009 in_data  input  WIDTH  operand bits.
REQ-010 in_mode  input  1  0 = bitwise AND of all bits; 1 = logical AND of lanes, where a lane is true if nonzero.
REQ-011 in_last  input  1  beat closes the current frame.
REQ-012 out_valid  output  1  frame result valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_and  output  1  AND over all beats of the frame.
REQ-015 out_count  output  CNT_W  beats in the frame, saturating.

Function
REQ-016 A beat SHALL transfer when in_valid and in_ready are both high; a result SHALL transfer when out_valid and out_ready are both high.
REQ-017 Per-beat reduction, mode 0: the AND of all WIDTH bits.
REQ-018 Per-beat reduction, mode 1: the AND over lanes of (lane != 0).
REQ-019 in_mode SHALL be sampled per beat; with LANE_W=1 both modes SHALL give the same result.
REQ-020 Stage 1 (s1) SHALL register the GROUP-wide partial ANDs, plus valid, last and mode-applied partials.
REQ-021 Stage 2 SHALL combine the partials into the beat result and hold frame state: acc (reset 1) and cnt (reset 0).
REQ-022 s1 SHALL advance into stage 2 only when out_valid is low or out_ready is high (s2_free).
REQ-023 in_ready SHALL equal (!s1_valid || s2_free); it SHALL depend combinationally only on registered state and out_ready.
REQ-024 Non-last beat entering stage 2: acc <= acc & beat; cnt <= sat(cnt+1); out_valid unchanged unless the current result is consumed.
REQ-025 Last beat entering stage 2: out_and <= acc & beat; out_count <= sat(cnt+1); out_valid <= 1; acc <= 1; cnt <= 0.
REQ-026 sat(x) SHALL clamp at 2^CNT_W-1; a counter at maximum SHALL stay at maximum.
REQ-027 Latency: a last beat accepted in cycle N with no stall SHALL give out_valid in cycle N+2.
REQ-028 Throughput: one beat per cycle while out_ready is held high.
REQ-029 out_valid SHALL drop after the result is consumed unless a new last beat enters the same cycle.
REQ-030 While out_valid is high and out_ready is low, out_and and out_count SHALL be stable; s1 SHALL hold; in_ready SHALL be low if s1 is occupied.
REQ-031 Exactly one result per frame; beats SHALL never be dropped or duplicated.
REQ-032 Results SHALL be produced in input order.

Reset
REQ-033 While rst is high: in_ready=0, s1_valid=0, out_valid=0, out_and=0, out_count=0, acc=1, cnt=0.
REQ-034 Reset mid-frame SHALL discard the partial frame; the next accepted beat SHALL start a new frame.
REQ-035 The first cycle after reset deassertion SHALL have in_ready=1.

Structure
REQ-036 A shared package SHALL hold the mode encoding constants (MODE_BITWISE=0, MODE_LOGICAL=1) and the lane-count/group-count derivation functions.
REQ-037 One sub-module, and_lane_group, SHALL be combinational: it reduces GROUP lanes under in_mode; stage 1 instantiates it ceil(lanes/GROUP) times.
REQ-038 All flops SHALL use the asynchronous reset; no latches; no combinational path from in_valid to in_ready.

Verification (WIDTH=8, LANE_W=2, GROUP=2, CNT_W=2 unless noted)
REQ-039 Single beat, in_data=0xFF, mode 0, last=1 -> out_and=1, out_count=1, out_valid exactly 2 cycles after acceptance.
REQ-040 Mode check: 0xFE with mode 0 -> out_and=0; 0x55 with mode 1 -> out_and=1; 0x54 with mode 1 -> out_and=0 (lane 0 zero).
REQ-041 Three-beat frame 0xFF, 0xFF, 0x7F (mode 0, last on the third beat) -> one result, out_and=0, out_count=3.
REQ-042 Backpressure: out_ready=0 for 6 cycles while 4 single-beat frames of 0xFF, 0x00, 0xFF, 0x00 are offered -> in_ready low after 2 are held; results 1, 0, 1, 0 delivered in order with out_ready high.
REQ-043 Reset mid-frame: 2 beats of 0x00 without last, then rst pulse, then 0xFF with last -> out_and=1, out_count=1.
REQ-044 Saturation: 5-beat frame of 0xFF -> out_count=3, out_and=1.

Source files
------------

// File: rtl/pipelined_and_reduce_pkg.sv
// Shared constants and parameter-derivation helpers for the pipelined AND reducer.
package pipelined_and_reduce_pkg;

    localparam logic MODE_BITWISE = 1'b0;
    localparam logic MODE_LOGICAL = 1'b1;

    function automatic int lane_count(input int width, input int lane_w);
        return width / lane_w;
    endfunction

    // Ceiling division: a trailing partial group still needs its own reducer.
    function automatic int group_count(input int lanes, input int group);
        return (lanes + group - 1) / group;
    endfunction

endpackage

// File: rtl/pipelined_and_reduce_if.sv
// Beat input and frame-result output channels of the pipelined AND reducer.
interface pipelined_and_reduce_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    // Both channels use valid/ready: a transfer happens on a rising clock edge where
    // valid and ready are both high; payload must stay stable while valid waits on ready.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_and;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_and, out_count
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_and, out_count
    );
endinterface

// File: rtl/pipelined_and_reduce_and_lane_group.sv
// Combinational AND of a group of lanes: all bits (bitwise mode) or lane-nonzero flags (logical mode).
module and_lane_group
    import pipelined_and_reduce_pkg::*;
#(
    parameter int LANE_W  = 1,
    parameter int N_LANES = 4
) (
    input  logic [N_LANES*LANE_W-1:0] i_lanes,
    input  logic                      i_mode,
    output logic                      o_and
);

    logic [N_LANES-1:0] w_lane_nz;

    always_comb begin
        w_lane_nz = '0;
        for (int l = 0; l < N_LANES; l++) begin
            w_lane_nz[l] = |i_lanes[l*LANE_W +: LANE_W];
        end
    end

    assign o_and = (i_mode == MODE_LOGICAL) ? &w_lane_nz : &i_lanes;

endmodule

// File: rtl/pipelined_and_reduce.sv
// Two-stage AND reducer: stage 1 registers per-group partials, stage 2 folds beats into frame results.
module pipelined_and_reduce
    import pipelined_and_reduce_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 1,
    parameter int GROUP  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pipelined_and_reduce_if.slave bus
);

    localparam int LANES = lane_count(WIDTH, LANE_W);
    localparam int NGRP  = group_count(LANES, GROUP);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NGRP-1:0]  w_part;
    logic             w_s2_free;
    logic             w_in_fire;
    logic             w_s1_adv;
    logic             w_out_fire;
    logic             w_beat;
    logic [CNT_W-1:0] w_cnt_inc;

    logic             r_s1_valid;
    logic             r_s1_last;
    logic [NGRP-1:0]  r_s1_part;
    logic             r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic             r_out_and;
    logic [CNT_W-1:0] r_out_count;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        localparam int LO = g * GROUP;
        localparam int NL = ((LANES - LO) < GROUP) ? (LANES - LO) : GROUP;
        and_lane_group #(
            .LANE_W  (LANE_W),
            .N_LANES (NL)
        ) u_grp (
            .i_lanes (bus.in_data[LO*LANE_W +: NL*LANE_W]),
            .i_mode  (bus.in_mode),
            .o_and   (w_part[g])
        );
    end

    assign w_s2_free  = !r_out_valid || bus.out_ready;
    // in_ready is built from registered state and out_ready only, never from in_valid.
    assign bus.in_ready = !rst && (!r_s1_valid || w_s2_free);
    assign w_in_fire  = bus.in_valid && bus.in_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    assign w_out_fire = r_out_valid && bus.out_ready;
    assign w_beat     = &r_s1_part;
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_part  <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_last  <= bus.in_last;
            r_s1_part  <= w_part;
        end else if (w_s2_free) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= 1'b1;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_and   <= 1'b0;
            r_out_count <= '0;
        end else if (w_s1_adv && r_s1_last) begin
            r_out_and   <= r_acc & w_beat;
            r_out_count <= w_cnt_inc;
            r_out_valid <= 1'b1;
            r_acc       <= 1'b1;
            r_cnt       <= '0;
        end else begin
            if (w_s1_adv) begin
                r_acc <= r_acc & w_beat;
                r_cnt <= w_cnt_inc;
            end
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_and   = r_out_and;
    assign bus.out_count = r_out_count;

endmodule

// File: tb/tb_pipelined_and_reduce.sv
// Self-checking bench: directed scenarios plus randomized frames against a frame-level reference model.
module tb_pipelined_and_reduce;

    localparam int WIDTH  = 8;
    localparam int LANE_W = 2;
    localparam int GROUP  = 2;
    localparam int CNT_W  = 2;
    localparam int LANES  = WIDTH / LANE_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_and_reduce_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    pipelined_and_reduce #(
        .WIDTH  (WIDTH),
        .LANE_W (LANE_W),
        .GROUP  (GROUP),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [CNT_W:0] exp_q[$];   // {and, count}
    bit   m_acc = 1'b1;
    int   m_cnt = 0;
    bit   stall_prev = 1'b0;
    logic hold_and;
    logic [CNT_W-1:0] hold_cnt;
    bit   rnd_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Frame semantics from first principles: bitwise mode needs every bit set,
    // logical mode needs every lane nonzero.
    function automatic bit beat_and(input logic [WIDTH-1:0] d, input logic mode);
        logic [WIDTH-1:0] v;
        if (mode == 1'b0) return d == {WIDTH{1'b1}};
        for (int i = 0; i < LANES; i++) begin
            v = d >> (i * LANE_W);
            if ((v & ((1 << LANE_W) - 1)) == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model and compare process, both sampled mid-cycle.
    initial begin
        logic [CNT_W:0] e;
        int c;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_acc = 1'b1;
                m_cnt = 0;
                stall_prev = 1'b0;
            end else begin
                if (bus.in_valid && bus.in_ready) begin
                    m_acc = m_acc & beat_and(bus.in_data, bus.in_mode);
                    m_cnt++;
                    if (bus.in_last) begin
                        c = (m_cnt > CMAX) ? CMAX : m_cnt;
                        e = {m_acc, c[CNT_W-1:0]};
                        exp_q.push_back(e);
                        m_acc = 1'b1;
                        m_cnt = 0;
                    end
                end
                if (stall_prev) begin
                    chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                    chk("hold_and", {31'd0, bus.out_and}, {31'd0, hold_and});
                    chk("hold_count", {30'd0, bus.out_count}, {30'd0, hold_cnt});
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_and", {31'd0, bus.out_and}, {31'd0, e[CNT_W]});
                        chk("res_count", {30'd0, bus.out_count}, {30'd0, e[CNT_W-1:0]});
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                hold_and   = bus.out_and;
                hold_cnt   = bus.out_count;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [WIDTH-1:0] d, input logic m, input logic l);
        int t;
        bus.in_data  = d;
        bus.in_mode  = m;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            t++;
            if (t > 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic frame1(input string name, input logic [WIDTH-1:0] d, input logic m, input logic exp_and);
        int c;
        send(d, m, 1'b1);
        wait_out(c);
        chk({name, "_latency"}, c, 32'd1);
        chk({name, "_and"}, {31'd0, bus.out_and}, {31'd0, exp_and});
        chk({name, "_count"}, {30'd0, bus.out_count}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [WIDTH-1:0] d;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_and", {31'd0, bus.out_and}, 32'd0);
        chk("rst_out_count", {30'd0, bus.out_count}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        frame1("ff_m0", 8'hFF, 1'b0, 1'b1);
        frame1("fe_m0", 8'hFE, 1'b0, 1'b0);
        frame1("55_m1", 8'h55, 1'b1, 1'b1);
        frame1("54_m1", 8'h54, 1'b1, 1'b0);
        frame1("55_m0", 8'h55, 1'b0, 1'b0);

        send(8'hFF, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        send(8'h7F, 1'b0, 1'b1);
        wait_out(c);
        chk("three_and", {31'd0, bus.out_and}, 32'd0);
        chk("three_count", {30'd0, bus.out_count}, 32'd3);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: two frames fill the pipeline, the third must wait.
        bus.out_ready = 1'b0;
        send(8'hFF, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b1);
        fork
            begin
                send(8'hFF, 1'b0, 1'b1);
                send(8'h00, 1'b0, 1'b1);
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
                chk("bp_first_and", {31'd0, bus.out_and}, 32'd1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;

        // Reset mid-frame discards the zero beats.
        send(8'h00, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'hFF, 1'b0, 1'b1);
        wait_out(c);
        chk("midrst_and", {31'd0, bus.out_and}, 32'd1);
        chk("midrst_count", {30'd0, bus.out_count}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) send(8'hFF, 1'b0, i == 4);
        wait_out(c);
        chk("sat_and", {31'd0, bus.out_and}, 32'd1);
        chk("sat_count", {30'd0, bus.out_count}, 32'd3);
        @(posedge clk);
        #1;

        // Randomized frames with random gaps and random downstream stalls.
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    case ($urandom_range(0, 3))
                        0: d = 8'hFF;
                        1: begin
                            for (int l = 0; l < LANES; l++)
                                d[l*LANE_W +: LANE_W] = LANE_W'($urandom_range(1, 3));
                        end
                        2: d = WIDTH'($urandom_range(0, 255));
                        default: d = 8'hFF ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                    endcase
                    send(d, 1'($urandom_range(0, 1)), (i == 399) || ($urandom_range(0, 2) == 0));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #0;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
